qspi_flash_cmd_mux: RTL

Pin-sharing stage between the XIP flash reader and the QSPI flash pads. In XIP mode it passes the reader's `sck`/`ce_n`/`dout`/`douten` straight to the pads. In command mode it takes the pins over and runs a register-driven, single-lane (SPI mode 0) byte shifter, so software running from SRAM can issue arbitrary flash commands (WREN, erase, program, status poll). The shifter is controlled through a zero-wait-state AHB-Lite slave.

---
 rtl/qspi_flash_cmd_mux.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/qspi_flash_cmd_mux.sv
// QSPI pad-sharing stage: passes the XIP reader through, or lets software drive a mode-0 SPI byte shifter over AHB-Lite.
// Define QSPI_CMD_IRQ_EN to add the transfer-complete irq output and STATUS bit2.
module qspi_flash_cmd_mux #(
  parameter int CLK_DIV = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        xip_sck,
  input  logic        xip_ce_n,
  input  logic [3:0]  xip_dout,
  input  logic        xip_douten,
  output logic [3:0]  xip_din,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dout,
  output logic [3:0]  douten,
  input  logic [3:0]  din
`ifdef QSPI_CMD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

  state_t           r_state, w_nextState;
  logic [DIV_W-1:0] r_divCnt;
  logic [2:0]       r_bitCnt;
  logic [7:0]       r_tx, r_rx, r_rxData;
  logic             r_sck, r_mode, r_cs, r_owned;
  logic             r_dpValid, r_dpWrite;
  logic [1:0]       r_dpAddr;
  logic             w_busy, w_divDone, w_rise, w_fall, w_done;
  logic             w_wr, w_rd, w_wrCtrl, w_start, w_irqFlag;
  logic             w_unused;

  assign w_unused  = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:8], HTRANS[0]};
  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dpValid <= 1'b0;
      r_dpWrite <= 1'b0;
      r_dpAddr  <= 2'd0;
    end else if (HREADY) begin
      r_dpValid <= HSEL & HTRANS[1];
      r_dpWrite <= HWRITE;
      r_dpAddr  <= HADDR[3:2];
    end
  end

  assign w_busy    = (r_state != ST_IDLE);
  assign w_wr      = r_dpValid & r_dpWrite & HREADY;
  assign w_rd      = r_dpValid & ~r_dpWrite & HREADY;
  assign w_wrCtrl  = w_wr & (r_dpAddr == 2'd0) & ~w_busy;
  assign w_start   = w_wr & (r_dpAddr == 2'd1) & r_owned & ~w_busy;
  assign w_divDone = (r_divCnt == DIV_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_mode <= 1'b0;
      r_cs   <= 1'b0;
    end else if (w_wrCtrl) begin
      r_mode <= HWDATA[0];
      r_cs   <= HWDATA[1];
    end
  end

  // Ownership only moves while the other side is quiet: XIP idle to grab, shifter idle to release.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_owned <= 1'b0;
    else if (r_mode && xip_ce_n)
      r_owned <= 1'b1;
    else if (!r_mode && !w_busy)
      r_owned <= 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_nextState = ST_LOW;
      ST_LOW: begin
        if (w_divDone) begin
          w_nextState = ST_HIGH;
          w_rise      = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_divDone) begin
          if (r_bitCnt == 3'd7) begin
            w_nextState = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_nextState = ST_LOW;
            w_fall      = 1'b1;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Shifter datapath: sample IO1 on the rising SCK edge, advance the MSB-first TX byte on the falling edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_divCnt <= '0;
      r_bitCnt <= 3'd0;
      r_tx     <= 8'd0;
      r_rx     <= 8'd0;
      r_rxData <= 8'd0;
      r_sck    <= 1'b0;
    end else if (w_start) begin
      r_tx     <= HWDATA[7:0];
      r_bitCnt <= 3'd0;
      r_divCnt <= '0;
      r_sck    <= 1'b0;
    end else if (w_busy) begin
      r_divCnt <= w_divDone ? '0 : r_divCnt + DIV_W'(1);
      if (w_rise) begin
        r_sck <= 1'b1;
        r_rx  <= {r_rx[6:0], din[1]};
      end
      if (w_fall) begin
        r_sck    <= 1'b0;
        r_tx     <= {r_tx[6:0], 1'b0};
        r_bitCnt <= r_bitCnt + 3'd1;
      end
      if (w_done) begin
        r_sck    <= 1'b0;
        r_rxData <= r_rx;
      end
    end
  end

`ifdef QSPI_CMD_IRQ_EN
  logic r_irq;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_irq <= 1'b0;
    else if (w_done)
      r_irq <= 1'b1;
    else if (w_rd && (r_dpAddr == 2'd2))
      r_irq <= 1'b0;
  end

  assign irq       = r_irq;
  assign w_irqFlag = r_irq;
`else
  assign w_irqFlag = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    case (r_dpAddr)
      2'd0:    HRDATA[1:0] = {r_cs, r_mode};
      2'd2:    HRDATA[7:0] = r_rxData;
      2'd3:    HRDATA[2:0] = {w_irqFlag, r_owned, w_busy};
      default: HRDATA = '0;
    endcase
  end

  // IO1 stays an input in command mode; WP#/HOLD# are parked high.
  always_comb begin
    xip_din = din;
    if (r_owned) begin
      sck    = r_sck;
      ce_n   = ~r_cs;
      dout   = {2'b11, 1'b0, r_tx[7]};
      douten = 4'b1101;
    end else begin
      sck    = xip_sck;
      ce_n   = xip_ce_n;
      dout   = xip_dout;
      douten = {4{xip_douten}};
    end
  end

endmodule
